// File: rtl/branch_cmp_seq.sv
// rtl/branch_cmp_seq.sv - multi-cycle MSB-first branch comparator
//
// Purpose: compares two N-bit operands D bits per cycle, MSB first, and
// returns less-than, equal and branch-taken flags for a RISC-V branch funct3.
// Signed compares bias both operands to offset binary by flipping bit N-1,
// so the scan itself is always unsigned.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   valid_i / ready_o  request handshake (a, b, funct3 sampled on accept)
//   valid_o / ready_i  result handshake (lt_o, eq_o, taken_o held in DONE)
//
// Configuration macro BRANCH_CMP_EARLY_EXIT_EN:
//   defined   - scan stops at the first differing chunk
//   undefined - first difference kept in a sticky register, fixed N/D latency
module branch_cmp_seq #(
   parameter int N = 32,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   funct3,
   output logic         valid_o,
   input  logic         ready_i,
   output logic         lt_o,
   output logic         eq_o,
   output logic         taken_o
);

   localparam int NCH = N / D;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d;
   logic [2:0]     f3_q, f3_d;
   logic [KW-1:0]  k_q, k_d;
   logic           lt_q, lt_d, eq_q, eq_d, taken_q, taken_d;
`ifndef BRANCH_CMP_EARLY_EXIT_EN
   logic           diff_q, diff_d, slt_q, slt_d;
`endif

   // Operands are shifted left each SCAN cycle, so the current chunk is
   // always the top D bits; this avoids a wide chunk-select mux.
   logic [D-1:0]   chunk_a, chunk_b;
   logic           chunk_diff, chunk_lt, last, in_signed;
   logic           fin, lt_n, eq_n;

   assign chunk_a    = a_q[N-1 -: D];
   assign chunk_b    = b_q[N-1 -: D];
   assign chunk_diff = (chunk_a != chunk_b);
   assign chunk_lt   = (chunk_a < chunk_b);
   assign last       = (k_q == KW'(NCH - 1));
   assign in_signed  = (funct3 == 3'b100) || (funct3 == 3'b101);

   function automatic logic taken_f(input logic [2:0] f3, input logic lt, input logic eq);
      case (f3)
         3'b000:          taken_f = eq;
         3'b001:          taken_f = !eq;
         3'b100, 3'b110:  taken_f = lt;
         3'b101, 3'b111:  taken_f = !lt;
         default:         taken_f = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      f3_d    = f3_q;
      k_d     = k_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      taken_d = taken_q;
      fin     = 1'b0;
      lt_n    = 1'b0;
      eq_n    = 1'b0;
`ifndef BRANCH_CMP_EARLY_EXIT_EN
      diff_d  = diff_q;
      slt_d   = slt_q;
`endif
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               a_d     = in_signed ? (a ^ MSB_MASK) : a;
               b_d     = in_signed ? (b ^ MSB_MASK) : b;
               f3_d    = funct3;
               k_d     = '0;
               state_d = SCAN;
`ifndef BRANCH_CMP_EARLY_EXIT_EN
               diff_d  = 1'b0;
               slt_d   = 1'b0;
`endif
            end
         end
         SCAN: begin
            a_d = a_q << D;
            b_d = b_q << D;
            k_d = k_q + 1'b1;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
            if (chunk_diff) begin
               fin  = 1'b1;
               lt_n = chunk_lt;
               eq_n = 1'b0;
            end else if (last) begin
               fin  = 1'b1;
               lt_n = 1'b0;
               eq_n = 1'b1;
            end
`else
            if (last) begin
               // chunk_lt is 0 when the final chunks match, so it is the
               // correct answer whenever no earlier difference was seen.
               fin  = 1'b1;
               lt_n = diff_q ? slt_q : chunk_lt;
               eq_n = !diff_q && !chunk_diff;
            end else if (!diff_q && chunk_diff) begin
               diff_d = 1'b1;
               slt_d  = chunk_lt;
            end
`endif
            if (fin) begin
               state_d = DONE;
               k_d     = '0;
               lt_d    = lt_n;
               eq_d    = eq_n;
               taken_d = taken_f(f3_q, lt_n, eq_n);
            end
         end
         DONE: begin
            if (ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         f3_q    <= '0;
         k_q     <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         taken_q <= 1'b0;
`ifndef BRANCH_CMP_EARLY_EXIT_EN
         diff_q  <= 1'b0;
         slt_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f3_q    <= f3_d;
         k_q     <= k_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         taken_q <= taken_d;
`ifndef BRANCH_CMP_EARLY_EXIT_EN
         diff_q  <= diff_d;
         slt_q   <= slt_d;
`endif
      end
   end

   assign ready_o = (state_q == IDLE);
   assign valid_o = (state_q == DONE);
   assign lt_o    = lt_q;
   assign eq_o    = eq_q;
   assign taken_o = taken_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// tb/tb_branch_cmp_seq.sv - directed self-checking bench for branch_cmp_seq
module tb_branch_cmp_seq;

   localparam int N = 32;
   localparam int D = 4;
   localparam int FULL_LAT = N / D;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
   localparam int LAT_C0 = 1;
`else
   localparam int LAT_C0 = FULL_LAT;
`endif

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         valid_i = 1'b0;
   logic         ready_o;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [2:0]   funct3 = 3'b000;
   logic         valid_o;
   logic         ready_i = 1'b0;
   logic         lt_o, eq_o, taken_o;

   int checks = 0;
   int failures = 0;

   branch_cmp_seq #(.N(N), .D(D)) dut (
      .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(ready_o),
      .a(a), .b(b), .funct3(funct3), .valid_o(valid_o), .ready_i(ready_i),
      .lt_o(lt_o), .eq_o(eq_o), .taken_o(taken_o)
   );

   always #5 clk = ~clk;

   // Drives one request and returns the number of rising edges from the
   // accepting edge until valid_o is seen (-1 on timeout). Inputs change and
   // outputs are sampled on the falling edge.
   task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic [2:0] tf,
                        input logic hold_valid, output int lat);
      @(negedge clk);
      a = ta; b = tb_; funct3 = tf; valid_i = 1'b1;
      @(negedge clk);
      if (!hold_valid) valid_i = 1'b0;
      else begin a = ~ta; b = ~tb_; funct3 = 3'b111; end
      lat = 0;
      while (!valid_o && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!valid_o) lat = -1;
   endtask

   task automatic release_result();
      ready_i = 1'b1;
      valid_i = 1'b0;
      @(negedge clk);
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      checks++; if (lt_o !== 1'b0) begin failures++; $display("FAIL reset_lt got=%b exp=0", lt_o); end
      checks++; if (eq_o !== 1'b0) begin failures++; $display("FAIL reset_eq got=%b exp=0", eq_o); end
      checks++; if (taken_o !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", taken_o); end
   endtask

   task automatic test_signed_unsigned();
      int lat;
      // BLT -1 < 1: biased 7FFF_FFFF vs 8000_0001 differ in chunk 0
      issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b0, lat);
      checks++; if (lat !== LAT_C0) begin failures++; $display("FAIL blt_lat got=%0d exp=%0d", lat, LAT_C0); end
      checks++; if (lt_o !== 1'b1) begin failures++; $display("FAIL blt_lt got=%b exp=1", lt_o); end
      checks++; if (taken_o !== 1'b1) begin failures++; $display("FAIL blt_taken got=%b exp=1", taken_o); end
      release_result();
      issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, lat);
      checks++; if (lat !== LAT_C0) begin failures++; $display("FAIL bltu_lat got=%0d exp=%0d", lat, LAT_C0); end
      checks++; if (lt_o !== 1'b0) begin failures++; $display("FAIL bltu_lt got=%b exp=0", lt_o); end
      checks++; if (taken_o !== 1'b0) begin failures++; $display("FAIL bltu_taken got=%b exp=0", taken_o); end
      release_result();
      issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 1'b0, lat);
      checks++; if (taken_o !== 1'b1) begin failures++; $display("FAIL bgeu_taken got=%b exp=1", taken_o); end
      checks++; if (eq_o !== 1'b0) begin failures++; $display("FAIL bgeu_eq got=%b exp=0", eq_o); end
      release_result();
   endtask

   task automatic test_early_exit();
      int lat;
      issue(32'h1000_0000, 32'h2000_0000, 3'b100, 1'b0, lat);
      checks++; if (lat !== LAT_C0) begin failures++; $display("FAIL early_lat got=%0d exp=%0d", lat, LAT_C0); end
      checks++; if (lt_o !== 1'b1) begin failures++; $display("FAIL early_lt got=%b exp=1", lt_o); end
      checks++; if (eq_o !== 1'b0) begin failures++; $display("FAIL early_eq got=%b exp=0", eq_o); end
      checks++; if (taken_o !== 1'b1) begin failures++; $display("FAIL early_taken got=%b exp=1", taken_o); end
      release_result();
   endtask

   task automatic test_equal();
      int lat;
      issue(32'h8000_0000, 32'h8000_0000, 3'b000, 1'b0, lat);
      checks++; if (lat !== FULL_LAT) begin failures++; $display("FAIL beq_lat got=%0d exp=%0d", lat, FULL_LAT); end
      checks++; if (eq_o !== 1'b1) begin failures++; $display("FAIL beq_eq got=%b exp=1", eq_o); end
      checks++; if (lt_o !== 1'b0) begin failures++; $display("FAIL beq_lt got=%b exp=0", lt_o); end
      checks++; if (taken_o !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", taken_o); end
      release_result();
      issue(32'h8000_0000, 32'h8000_0000, 3'b001, 1'b0, lat);
      checks++; if (lat !== FULL_LAT) begin failures++; $display("FAIL bne_lat got=%0d exp=%0d", lat, FULL_LAT); end
      checks++; if (eq_o !== 1'b1) begin failures++; $display("FAIL bne_eq got=%b exp=1", eq_o); end
      checks++; if (taken_o !== 1'b0) begin failures++; $display("FAIL bne_taken got=%b exp=0", taken_o); end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      // BGE 5 vs 6: first difference in the last chunk, so full latency in
      // both builds; valid_i stays high with swapped operands while busy.
      issue(32'h0000_0005, 32'h0000_0006, 3'b101, 1'b1, lat);
      checks++; if (lat !== FULL_LAT) begin failures++; $display("FAIL bp_lat got=%0d exp=%0d", lat, FULL_LAT); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, valid_o); end
         checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, ready_o); end
         checks++; if ({lt_o, eq_o, taken_o} !== 3'b100) begin failures++; $display("FAIL bp_flags[%0d] got=%b exp=100", i, {lt_o, eq_o, taken_o}); end
         @(negedge clk);
      end
      release_result();
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", ready_o); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_valid_after got=%b exp=0", valid_o); end
   endtask

   task automatic test_illegal_funct3();
      int lat;
      issue(32'd3, 32'd9, 3'b010, 1'b0, lat);
      checks++; if (lat !== FULL_LAT) begin failures++; $display("FAIL ill_lat got=%0d exp=%0d", lat, FULL_LAT); end
      checks++; if ({lt_o, eq_o, taken_o} !== 3'b100) begin failures++; $display("FAIL ill_flags got=%b exp=100", {lt_o, eq_o, taken_o}); end
      release_result();
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      // Flags still hold lt_o=1 from the previous result here.
      @(negedge clk);
      a = 32'd5; b = 32'd6; funct3 = 3'b100; valid_i = 1'b1;
      @(negedge clk);             // first SCAN cycle
      valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);             // third SCAN cycle
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", ready_o); end
      rstn = 1'b0;
      #1;
      checks++; if ({ready_o, valid_o, lt_o, eq_o, taken_o} !== 5'b10000)
         begin failures++; $display("FAIL mid_reset got=%b exp=10000", {ready_o, valid_o, lt_o, eq_o, taken_o}); end
      @(negedge clk);
      rstn = 1'b1;
      issue(32'd7, 32'd7, 3'b000, 1'b0, lat);
      checks++; if (lat !== FULL_LAT) begin failures++; $display("FAIL post_lat got=%0d exp=%0d", lat, FULL_LAT); end
      checks++; if ({lt_o, eq_o, taken_o} !== 3'b011) begin failures++; $display("FAIL post_flags got=%b exp=011", {lt_o, eq_o, taken_o}); end
      release_result();
   endtask

   initial begin
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rstn = 1'b1;
      test_signed_unsigned();
      test_early_exit();
      test_equal();
      test_backpressure();
      test_illegal_funct3();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
